// File: rtl/mem_access_stage_if.sv
// Data-memory port of the memory-access stage.
// The stage is the master; the data memory is the slave.
interface mem_access_stage_if;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byteen;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  modport master (
    output dm_addr,
    output dm_wdata,
    output dm_byteen,
    output dm_we,
    output dm_pc,
    input  dm_rdata
  );

  modport slave (
    input  dm_addr,
    input  dm_wdata,
    input  dm_byteen,
    input  dm_we,
    input  dm_pc,
    output dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: E/M register, byte enables, AdEL/AdES
// detection, data-memory drive and load extension into M/W.
module mem_access_stage #(
  parameter logic [31:0] DM_BYTES = 32'h0000_4000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     e_valid,
  input  logic [3:0]               e_memop,
  input  logic [31:0]              e_addr,
  input  logic [31:0]              e_wdata,
  input  logic [4:0]               e_wreg,
  input  logic [31:0]              e_pc,
  mem_access_stage_if.master       dm,
  output logic                     m_exc,
  output logic [4:0]               m_exccode,
  output logic [31:0]              m_badvaddr,
  output logic                     w_valid,
  output logic [4:0]               w_wreg,
  output logic [31:0]              w_data,
  output logic [31:0]              w_pc
);
  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [31:0] pc;
  } m_reg_t;

  m_reg_t      m_q;
  logic [1:0]  a;
  logic        is_w, is_h, is_b;
  logic        is_load, is_store, sext;
  logic        misal, oor, exc;
  logic [3:0]  ben;
  logic [15:0] half;
  logic [7:0]  byt;
  logic [31:0] ldata;
  logic        w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
    end else if (flush) begin
      m_q <= '0;
    end else if (!stall) begin
      m_q.valid <= e_valid & (e_memop >= OP_LW)
                 & (e_memop <= OP_SB);
      m_q.op    <= e_memop;
      m_q.addr  <= e_addr;
      m_q.wdata <= e_wdata;
      m_q.wreg  <= e_wreg;
      m_q.pc    <= e_pc;
    end
  end

  assign a = m_q.addr[1:0];

  always_comb begin
    is_w     = (m_q.op == OP_LW) | (m_q.op == OP_SW);
    is_h     = (m_q.op == OP_LH) | (m_q.op == OP_LHU)
             | (m_q.op == OP_SH);
    is_b     = (m_q.op == OP_LB) | (m_q.op == OP_LBU)
             | (m_q.op == OP_SB);
    is_load  = (m_q.op >= OP_LW) & (m_q.op <= OP_LBU);
    is_store = (m_q.op >= OP_SW) & (m_q.op <= OP_SB);
    sext     = (m_q.op == OP_LH) | (m_q.op == OP_LB);
  end

  always_comb begin
    ben = 4'b0000;
    unique case (1'b1)
      is_w:    ben = 4'b1111;
      is_h:    ben = a[1] ? 4'b1100 : 4'b0011;
      is_b:    ben = 4'b0001 << a;
      default: ben = 4'b0000;
    endcase
  end

  // Range check has no wrap: addresses near 2^32 fault here.
  assign misal = (is_w & (a != 2'b00)) | (is_h & a[0]);
  assign oor   = m_q.addr >= DM_BYTES;
  assign exc   = m_q.valid & (misal | oor);

  assign m_exc      = exc;
  assign m_exccode  = !exc     ? 5'd0 :
                      is_store ? 5'd5 : 5'd4;
  assign m_badvaddr = exc ? m_q.addr : 32'h0;

  assign dm.dm_addr   = m_q.addr;
  assign dm.dm_wdata  = m_q.wdata;
  assign dm.dm_pc     = m_q.pc;
  assign dm.dm_byteen = (m_q.valid & ~exc) ? ben : 4'b0000;
  assign dm.dm_we     = m_q.valid & is_store & ~exc & ~stall;

  always_comb begin
    half = a[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
    case (a)
      2'd0:    byt = dm.dm_rdata[7:0];
      2'd1:    byt = dm.dm_rdata[15:8];
      2'd2:    byt = dm.dm_rdata[23:16];
      default: byt = dm.dm_rdata[31:24];
    endcase
    ldata = '0;
    unique case (1'b1)
      is_w:    ldata = dm.dm_rdata;
      is_h:    ldata = sext ? {{16{half[15]}}, half}
                            : {16'h0, half};
      is_b:    ldata = sext ? {{24{byt[7]}}, byt}
                            : {24'h0, byt};
      default: ldata = '0;
    endcase
  end

  assign w_load = m_q.valid & is_load & ~exc & ~stall & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_data  <= '0;
      w_wreg  <= '0;
      w_pc    <= '0;
    end else if (w_load) begin
      w_valid <= 1'b1;
      w_data  <= ldata;
      w_wreg  <= m_q.wreg;
      w_pc    <= m_q.pc;
    end else begin
      w_valid <= 1'b0;
      w_data  <= '0;
      w_wreg  <= '0;
      w_pc    <= '0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage against a byte-level
// transaction model of the memory stage.
`timescale 1ns/1ps
module tb_mem_access_stage;
  localparam logic [31:0] DMB = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, e_valid;
  logic [3:0]  e_memop;
  logic [31:0] e_addr, e_wdata, e_pc;
  logic [4:0]  e_wreg;
  logic        m_exc, w_valid;
  logic [4:0]  m_exccode, w_wreg;
  logic [31:0] m_badvaddr, w_data, w_pc;

  always #5 clk = ~clk;

  mem_access_stage_if dm_bus ();

  mem_access_stage #(.DM_BYTES(DMB)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .e_valid(e_valid), .e_memop(e_memop), .e_addr(e_addr),
    .e_wdata(e_wdata), .e_wreg(e_wreg), .e_pc(e_pc),
    .dm(dm_bus),
    .m_exc(m_exc), .m_exccode(m_exccode), .m_badvaddr(m_badvaddr),
    .w_valid(w_valid), .w_wreg(w_wreg), .w_data(w_data), .w_pc(w_pc)
  );

  // Data memory: word array, lanes steered from the byte enables
  logic [31:0] dmem [0:4095];
  logic [11:0] widx;
  assign widx = dm_bus.dm_addr[13:2];
  assign dm_bus.dm_rdata = dmem[widx];

  always @(posedge clk) begin
    if (dm_bus.dm_we) begin
      case (dm_bus.dm_byteen)
        4'b1111: dmem[widx]        <= dm_bus.dm_wdata;
        4'b0011: dmem[widx][15:0]  <= dm_bus.dm_wdata[15:0];
        4'b1100: dmem[widx][31:16] <= dm_bus.dm_wdata[15:0];
        4'b0001: dmem[widx][7:0]   <= dm_bus.dm_wdata[7:0];
        4'b0010: dmem[widx][15:8]  <= dm_bus.dm_wdata[7:0];
        4'b0100: dmem[widx][23:16] <= dm_bus.dm_wdata[7:0];
        4'b1000: dmem[widx][31:24] <= dm_bus.dm_wdata[7:0];
        default: ;
      endcase
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cyc=%0d",
               nm, act, req, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] addr, wdata, pc;
    logic [4:0]  wreg;
  } txn_t;

  typedef struct {
    int          cyc;
    logic [31:0] a, b, c, d;
  } exp_t;

  logic [7:0] rmem [0:16383];
  txn_t  ms;
  exp_t  wq[$];
  exp_t  xq[$];
  exp_t  lq[$];

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd6:       return 4;
      4'd2, 4'd3, 4'd7: return 2;
      4'd4, 4'd5, 4'd8: return 1;
      default:          return 0;
    endcase
  endfunction

  task automatic model_cycle(input logic st, input logic fl);
    int sz;
    bit ld, sto, sg, fault;
    logic [31:0] d;
    logic [13:0] ba;
    exp_t e;
    if (ms.v) begin
      sz    = op_size(ms.op);
      ld    = ms.op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      sto   = ms.op inside {4'd6, 4'd7, 4'd8};
      sg    = ms.op inside {4'd2, 4'd4};
      fault = (ms.addr % sz != 0) || (ms.addr >= DMB);
      ba    = ms.addr[13:0];
      if (fault) begin
        e = '{cyc, sto ? 32'd5 : 32'd4, ms.addr, 0, 0};
        xq.push_back(e);
      end else if (sto && !st) begin
        for (int k = 0; k < sz; k++)
          rmem[ba + 14'(k)] = ms.wdata[8*k +: 8];
        e.cyc = cyc;
        e.a = ms.addr;
        e.b = ((32'd1 << sz) - 1) << (ms.addr % 4);
        e.c = ms.wdata;
        e.d = ms.pc;
        wq.push_back(e);
      end else if (ld && !st && !fl) begin
        d = 0;
        for (int k = 0; k < sz; k++)
          d[8*k +: 8] = rmem[ba + 14'(k)];
        if (sg && d[8*sz-1])
          for (int k = 8*sz; k < 32; k++) d[k] = 1'b1;
        e = '{cyc + 1, 32'(ms.wreg), d, ms.pc, 0};
        lq.push_back(e);
      end
    end
    if (fl) begin
      ms = '{1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0};
    end else if (!st) begin
      ms.v     = e_valid && (e_memop >= 4'd1) && (e_memop <= 4'd8);
      ms.op    = e_memop;
      ms.addr  = e_addr;
      ms.wdata = e_wdata;
      ms.pc    = e_pc;
      ms.wreg  = e_wreg;
    end
  endtask

  task automatic step(input logic st, input logic fl,
                      input logic v, input logic [3:0] op,
                      input logic [31:0] ad, input logic [31:0] wd);
    @(posedge clk);
    #1;
    cyc++;
    stall   = st;
    flush   = fl;
    e_valid = v;
    e_memop = op;
    e_addr  = ad;
    e_wdata = wd;
    e_wreg  = 5'($urandom_range(1, 31));
    e_pc    = 32'h0040_0000 + 32'(cyc * 4);
    model_cycle(st, fl);
  endtask

  // Monitor
  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (dm_bus.dm_we) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", 64'(dm_bus.dm_we), 64'd0);
        end else begin
          me = wq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(me.cyc));
          chk("wr_addr", 64'(dm_bus.dm_addr), 64'(me.a));
          chk("wr_byteen", 64'(dm_bus.dm_byteen), 64'(me.b));
          chk("wr_wdata", 64'(dm_bus.dm_wdata), 64'(me.c));
          chk("wr_pc", 64'(dm_bus.dm_pc), 64'(me.d));
        end
      end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
        me = wq.pop_front();
        chk("wr_missing", 64'(dm_bus.dm_we), 64'd1);
      end
      if (m_exc) begin
        chk("exc_byteen", 64'(dm_bus.dm_byteen), 64'd0);
        if (xq.size() == 0) begin
          chk("exc_unexpected", 64'(m_exc), 64'd0);
        end else begin
          me = xq.pop_front();
          chk("exc_cycle", 64'(cyc), 64'(me.cyc));
          chk("exc_code", 64'(m_exccode), 64'(me.a));
          chk("exc_badvaddr", 64'(m_badvaddr), 64'(me.b));
        end
      end else begin
        chk("exc_idle", {27'd0, m_exccode, m_badvaddr}, 64'd0);
        if (xq.size() != 0 && xq[0].cyc <= cyc) begin
          me = xq.pop_front();
          chk("exc_missing", 64'(m_exc), 64'd1);
        end
      end
      if (w_valid) begin
        if (lq.size() == 0) begin
          chk("ld_unexpected", 64'(w_valid), 64'd0);
        end else begin
          me = lq.pop_front();
          chk("ld_cycle", 64'(cyc), 64'(me.cyc));
          chk("ld_wreg", 64'(w_wreg), 64'(me.a));
          chk("ld_data", 64'(w_data), 64'(me.b));
          chk("ld_pc", 64'(w_pc), 64'(me.c));
        end
      end else begin
        chk("ld_idle_data", 64'(w_data), 64'd0);
        if (lq.size() != 0 && lq[0].cyc <= cyc) begin
          me = lq.pop_front();
          chk("ld_missing", 64'(w_valid), 64'd1);
        end
      end
    end
  end

  function automatic logic [31:0] rnd_addr(input logic [3:0] op);
    int r;
    int sz;
    logic [31:0] x;
    r  = $urandom_range(0, 9);
    sz = op_size(op);
    x  = 32'($urandom_range(0, 63));
    if (r <= 5 && sz > 0) x = x & ~(32'(sz) - 1);
    else if (r == 8) x = 32'h3FF8 + 32'($urandom_range(0, 15));
    else if (r == 9) x = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return x;
  endfunction

  initial begin
    logic [3:0] op;
    for (int i = 0; i < 4096; i++) dmem[i] <= 32'h0;
    for (int i = 0; i < 16384; i++) rmem[i] = 8'h0;
    ms = '{1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0};
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    e_valid = 1'b0; e_memop = 4'd0; e_addr = 32'd0;
    e_wdata = 32'd0; e_wreg = 5'd0; e_pc = 32'd0;
    @(posedge clk);
    #1;
    chk("rst_we", 64'(dm_bus.dm_we), 64'd0);
    chk("rst_byteen", 64'(dm_bus.dm_byteen), 64'd0);
    chk("rst_dm_addr", 64'(dm_bus.dm_addr), 64'd0);
    chk("rst_exc", {m_exc, m_exccode, m_badvaddr}, 64'd0);
    chk("rst_w", {w_valid, w_wreg, w_data}, 64'd0);
    chk("rst_w_pc", 64'(w_pc), 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    step(0, 0, 1, 4'd6, 32'h10, 32'h1234_5678);
    step(0, 0, 1, 4'd1, 32'h10, 32'h0);
    step(0, 0, 1, 4'd8, 32'h21, 32'h0000_00AB);
    step(0, 0, 1, 4'd8, 32'h22, 32'h0000_00AB);
    step(0, 0, 1, 4'd8, 32'h23, 32'h0000_00AB);
    step(0, 0, 1, 4'd4, 32'h23, 32'h0);
    step(0, 0, 1, 4'd5, 32'h23, 32'h0);
    step(0, 0, 1, 4'd7, 32'h32, 32'h0000_8001);
    step(0, 0, 1, 4'd2, 32'h32, 32'h0);
    step(0, 0, 1, 4'd3, 32'h32, 32'h0);
    step(0, 0, 1, 4'd1, 32'h13, 32'h0);
    step(0, 0, 1, 4'd7, 32'h4000, 32'hBEEF);
    step(0, 0, 1, 4'd1, 32'h0, 32'h0);
    step(0, 0, 1, 4'd6, 32'h20, 32'hCAFE_F00D);
    step(1, 0, 0, 4'd0, 32'h0, 32'h0);
    step(1, 0, 0, 4'd0, 32'h0, 32'h0);
    step(1, 0, 0, 4'd0, 32'h0, 32'h0);
    step(0, 0, 1, 4'd1, 32'h20, 32'h0);
    step(0, 0, 1, 4'd6, 32'h40, 32'h5555_AAAA);
    step(1, 1, 0, 4'd0, 32'h0, 32'h0);
    step(0, 0, 1, 4'd1, 32'h40, 32'h0);
    step(0, 0, 0, 4'd0, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) != 0, op, rnd_addr(op), $urandom);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'd0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("xq_drained", 64'(xq.size()), 64'd0);
    chk("lq_drained", 64'(lq.size()), 64'd0);

    // Asynchronous reset with a load in W and a store in M
    @(posedge clk); #1;
    e_valid = 1'b1; e_memop = 4'd1; e_addr = 32'h10;
    @(posedge clk); #1;
    e_memop = 4'd6; e_addr = 32'h14; e_wdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    e_valid = 1'b0; e_memop = 4'd0;
    chk("pre_rst_we", 64'(dm_bus.dm_we), 64'd1);
    chk("pre_rst_wvalid", 64'(w_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_we", 64'(dm_bus.dm_we), 64'd0);
    chk("arst_exc", 64'(m_exc), 64'd0);
    chk("arst_wvalid", 64'(w_valid), 64'd0);
    chk("arst_byteen", 64'(dm_bus.dm_byteen), 64'd0);
    #3 reset = 1'b0;

    // Asynchronous reset with a faulting load in M
    @(posedge clk); #1;
    e_valid = 1'b1; e_memop = 4'd1; e_addr = 32'h13;
    @(posedge clk); #1;
    e_valid = 1'b0; e_memop = 4'd0;
    chk("pre_rst_exc", 64'(m_exc), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_exc2", {m_exc, m_exccode, m_badvaddr}, 64'd0);
    @(posedge clk); #1;
    chk("arst_hold_we", 64'(dm_bus.dm_we), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
